sevenseg_scanner: RTL and testbench

- Time-multiplexed driver for the Nexys 8-digit common-anode seven-segment display.
- Sits downstream of the RISC-V system and replaces the per-cycle seg1/seg2 toggle at board level.
- Drives one digit at a time at a fixed dwell, with a blanking gap between digits to suppress ghosting.
- New display contents are double-buffered and take effect only at frame boundaries, so no frame ever shows a mix of old and new values.

---
 rtl/sevenseg_pkg.sv | 22 ++
 rtl/hex7seg_decoder.sv | 13 +
 rtl/sevenseg_scanner.sv | 144 ++++++++++++++
 tb/tb_sevenseg_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display path: segment encoding,
// the hex decode table and the scan state type.
package sevenseg_pkg;

  // All segments off (active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for each hex digit 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {BLANK, SHOW} scan_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  import sevenseg_pkg::*;

  // Table lookup
  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit seven-segment
// display. Each digit slot starts with a blanking gap, display contents are
// double-buffered and swapped only at the frame boundary.
module sevenseg_scanner #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);
  import sevenseg_pkg::*;

  localparam int unsigned CW = $clog2(DIGIT_CYCLES);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] FD_CNT     = CW'(DIGIT_CYCLES - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
    $error("sevenseg_scanner: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES");
  end

  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] stg_val, act_val;
  logic [NUM_DIGITS-1:0]   stg_en, act_en, stg_dp, act_dp;
  logic                    pending;

  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  fd_d;

  // Scan state, slot counter and digit index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: blank gap, then show until slot end, then advance digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Staging captures every load; active swaps only on the frame_done cycle,
  // taking the live inputs when a load coincides with the boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_val <= '0;
      stg_en  <= '0;
      stg_dp  <= '0;
      act_val <= '0;
      act_en  <= '0;
      act_dp  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        stg_val <= value;
        stg_en  <= digit_en;
        stg_dp  <= dp_en;
        pending <= 1'b1;
      end
      if (frame_done && (pending || load)) begin
        act_val <= load ? value    : stg_val;
        act_en  <= load ? digit_en : stg_en;
        act_dp  <= load ? dp_en    : stg_dp;
        pending <= 1'b0;
      end
    end
  end

  assign cur_nib = act_val[{idx_q, 2'b00} +: 4];

  hex7seg_decoder u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  // Output selection for the current state; disabled digits stay fully dark
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = (idx_q == IDX_LAST) && (cnt_q == FD_CNT);
    if (state_q == SHOW && act_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~act_dp[idx_q];
    end
  end

  // Registered outputs, blanked immediately by reset.
  // frame_done is registered from the cycle before so it lines up with the
  // counter's last cycle of the final digit, which is the swap point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner (8 digits, 10-cycle slots, 2 blank).
// The reference model predicts outputs from the global cycle count since reset
// and a frame-level view of the staging/active buffers.
module tb_sevenseg_scanner;

  localparam int unsigned ND = 8;
  localparam int unsigned DC = 10;
  localparam int unsigned BC = 2;
  localparam int unsigned FRAME = ND * DC;

  logic          clk;
  logic          reset;
  logic [31:0]   value;
  logic [7:0]    digit_en;
  logic [7:0]    dp_en;
  logic          load;
  logic [6:0]    seg;
  logic          dp;
  logic [7:0]    an;
  logic          frame_done;

  sevenseg_scanner #(
    .NUM_DIGITS   (ND),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .digit_en   (digit_en),
    .dp_en      (dp_en),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] ref_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state
  int unsigned k = 0;
  logic [31:0] m_val, s_val;
  logic [7:0]  m_en, s_en, m_dp, s_dp;
  logic        pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_val = '0; m_en = '0; m_dp = '0;
    s_val = '0; s_en = '0; s_dp = '0;
    pend = 1'b0;
  endtask

  // One clock: advance model, then compare all outputs 1 time unit after the edge
  task automatic step();
    logic [31:0] pv;
    logic [7:0]  pe, pd, e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, bnd;
    int unsigned p, slot, off;
    logic [3:0]  nib;
    pv = m_val; pe = m_en; pd = m_dp;
    p = k % FRAME;
    bnd = (p == FRAME - 1);
    @(posedge clk);
    if (load) begin
      s_val = value; s_en = digit_en; s_dp = dp_en;
      pend = 1'b1;
    end
    if (bnd && pend) begin
      m_val = s_val; m_en = s_en; m_dp = s_dp;
      pend = 1'b0;
    end
    k++;
    slot = p / DC;
    off  = p % DC;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (off >= BC && pe[slot]) begin
      nib   = pv[slot*4 +: 4];
      e_an  = ~(8'h01 << slot);
      e_seg = ref_tbl[nib];
      e_dp  = ~pd[slot];
    end
    e_fd = ((k % FRAME) == FRAME - 1);
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("an_onehot_low", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run_to_pos(input int unsigned p);
    do step(); while ((k % FRAME) != p);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
    value = v; digit_en = e; dp_en = d; load = 1'b1;
    step();
    load = 1'b0;
    value = $urandom; digit_en = 8'($urandom); dp_en = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0;
    value = '0; digit_en = '0; dp_en = '0;
    model_reset();
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fd", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: dark, frame_done every 80 cycles
    repeat (200) step();

    // Basic scan
    do_load(32'h76543210, 8'hFF, 8'h01);
    run_to_pos(0);
    repeat (3) step();
    check("basic_d0_an", 32'(an), 32'hFE);
    check("basic_d0_seg", 32'(seg), 32'(7'b1000000));
    check("basic_d0_dp", 32'(dp), 32'd0);
    run_to_pos(0);

    // Tear-free update mid digit 3
    run_to_pos(35);
    do_load(32'hFFFFFFFF, 8'hFF, 8'h00);
    run_to_pos(46);
    check("tear_old_d4", 32'(seg), 32'(7'b0011001));
    run_to_pos(5);
    check("tear_new_d0", 32'(seg), 32'(7'b0001110));

    // Load coincident with frame_done
    run_to_pos(FRAME - 1);
    check("coll_fd_high", 32'(frame_done), 32'd1);
    do_load(32'h00000008, 8'hFF, 8'h00);
    run_to_pos(5);
    check("coll_d0_seg", 32'(seg), 32'(7'b0000000));

    // Masked digits
    do_load($urandom, 8'b10100101, 8'($urandom));
    run_to_pos(0);
    run_to_pos(0);

    // Randomized loads, including overwrites before the boundary
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 120)) step();
      do_load($urandom, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 40)) step();
        do_load($urandom, 8'($urandom), 8'($urandom));
      end
    end
    repeat (170) step();

    // Asynchronous reset during digit 5 show
    do_load($urandom, 8'hFF, 8'($urandom));
    run_to_pos(0);
    run_to_pos(56);
    check("pre_rst_an", 32'(an), 32'hDF);
    #2 reset = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hFF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp", 32'(dp), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (100) step();
    check("post_rst_dark", 32'(an), 32'hFF);
    do_load(32'h89ABCDEF, 8'hFF, 8'hFF);
    repeat (170) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
